// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory unit
package dmem_pkg;
  typedef enum logic [2:0] {
    AM_B  = 3'b000,
    AM_H  = 3'b001,
    AM_W  = 3'b010,
    AM_D  = 3'b011,
    AM_BU = 3'b100,
    AM_HU = 3'b101,
    AM_WU = 3'b110
  } addrmode_e;
  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, RESP, ERR} state_e;
  function automatic logic [3:0] size_of(logic [2:0] m);
    return m == AM_B || m == AM_BU ? 4'd1 :
           m == AM_H || m == AM_HU ? 4'd2 :
           m == AM_W || m == AM_WU ? 4'd4 : 4'd8;
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: single-port word RAM with per-byte write enables and registered read
module dmem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [DATA_WIDTH/8-1:0]        we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: handshaked RISC-V load/store controller over a byte-lane RAM bank
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter bit ALLOW_MISALIGNED = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_addrmode,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int WI = $clog2(DEPTH_WORDS);
  localparam logic [2*NB-1:0] LANE1 = 1;
  state_e st, nxt;
  addrmode_e mode;
  logic wr, split, rq_split, rq_ok, unused_addr;
  logic [OFF-1:0] off;
  logic [WI-1:0] idx, bank_addr;
  logic [3:0] sz;
  logic [NB-1:0] we;
  logic [2*NB-1:0] bm;
  logic [2*DATA_WIDTH-1:0] ww, rw;
  logic [DATA_WIDTH-1:0] wd, lo, rdata, bank_wdata, val, km, ext;
  assign unused_addr = ^req_address[ADDRESS_WIDTH-1:WI+OFF];
  dmem_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk(clk),
    .we(we),
    .addr(bank_addr),
    .wdata(bank_wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= 1'b0;
      mode <= AM_B;
      off <= '0;
      idx <= '0;
      wd <= '0;
      split <= 1'b0;
      lo <= '0;
    end else begin
      if (req_valid && st == IDLE) begin
        wr <= req_write;
        mode <= addrmode_e'(req_addrmode);
        off <= req_address[OFF-1:0];
        idx <= req_address[WI+OFF-1:OFF];
        wd <= req_wdata;
        split <= rq_split;
      end
      if (st == BEAT2) lo <= rdata;
    end
  always_comb begin
    rq_split = 32'(req_address[OFF-1:0]) + 32'(size_of(req_addrmode)) > 32'(NB);
    rq_ok = req_addrmode != 3'b111 &&
            (DATA_WIDTH == 64 || (req_addrmode != AM_D && req_addrmode != AM_WU)) &&
            (ALLOW_MISALIGNED || !rq_split);
    sz = size_of(mode);
    bm = ((LANE1 << sz) - LANE1) << off;
    ww = {{DATA_WIDTH{1'b0}}, wd} << {off, 3'b000};
    we = !wr ? '0 : st == BEAT1 ? bm[NB-1:0] : st == BEAT2 ? bm[2*NB-1:NB] : '0;
    bank_addr = st == BEAT2 ? idx + 1'b1 : idx;
    bank_wdata = st == BEAT2 ? ww[2*DATA_WIDTH-1:DATA_WIDTH] : ww[DATA_WIDTH-1:0];
    rw = {split ? rdata : {DATA_WIDTH{1'b0}}, split ? lo : rdata} >> {off, 3'b000};
    val = rw[DATA_WIDTH-1:0];
    km = ~({DATA_WIDTH{1'b1}} << {sz, 3'b000});
    ext = !mode[2] && |(val & (km ^ (km >> 1))) ? val | ~km : val & km;
    nxt = st == IDLE  ? (req_valid ? (rq_ok ? BEAT1 : ERR) : IDLE) :
          st == BEAT1 ? (split ? BEAT2 : RESP) :
          st == BEAT2 ? RESP : IDLE;
    req_ready = st == IDLE;
    resp_valid = st == RESP || st == ERR;
    resp_err = st == ERR;
    resp_rdata = st == RESP && !wr ? ext : '0;
  end
endmodule
